ram32_stream_loader: RTL

- Byte-stream front end for the 32x32-bit DFF RAM macro.
- Write path: packs incoming bytes into 32-bit words and issues byte-masked word writes at auto-incrementing addresses.
- Read path: fetches words and serialises them back out as a byte stream with valid/ready flow control.
- Sits directly upstream of the RAM and drives its EN/A/WE/Di pins; consumes its Do.

---
 rtl/ram32_loader_pkg.sv | 25 ++
 rtl/ram32_byte_packer.sv | 36 +++
 rtl/ram32_stream_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ram32_loader_pkg.sv
// rtl/ram32_loader_pkg.sv - shared FSM states, RAM constants and lane-to-bit mapping (byte order selected by RAM_LOADER_BIG_ENDIAN_EN)
package ram32_loader_pkg;

    localparam int RAM_WORDS      = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    // Bit offset of a stream lane inside the 32-bit word; bits 4:3 double as the byte-enable index.
    function automatic logic [4:0] lane_offset(input logic [1:0] lane);
`ifdef RAM_LOADER_BIG_ENDIAN_EN
        lane_offset = {~lane, 3'b000};
`else
        lane_offset = {lane, 3'b000};
`endif
    endfunction

endpackage

// File: rtl/ram32_byte_packer.sv
// rtl/ram32_byte_packer.sv - write-path lane counter, word buffer and byte mask (byte order selected by RAM_LOADER_BIG_ENDIAN_EN)
module ram32_byte_packer
    import ram32_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic [3:0]  mask
);

    logic [4:0] off;

    assign off = lane_offset(lane);

    // Drop each accepted byte into its lane and mark that byte enable; clear restarts a fresh word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= 2'd0;
            word <= 32'd0;
            mask <= 4'd0;
        end else if (clear) begin
            lane <= 2'd0;
            word <= 32'd0;
            mask <= 4'd0;
        end else if (accept) begin
            word[off +: 8]  <= byte_in;
            mask[off[4:3]]  <= 1'b1;
            lane            <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/ram32_stream_loader.sv
// rtl/ram32_stream_loader.sv - byte-stream loader/reader for the 32x32 DFF RAM (byte order selected by RAM_LOADER_BIG_ENDIAN_EN)
module ram32_stream_loader
    import ram32_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_start,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_a,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_di,
    input  logic [31:0]       ram_do
);

    localparam int         WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    remaining_q;
    logic [1:0]          rd_lane_q;
    logic [31:0]         shreg_q;
    logic [WAIT_W-1:0]   wait_q;
    logic                last_q;

    logic                pk_clear;
    logic                pk_accept;
    logic [1:0]          pk_lane;
    logic [31:0]         pk_word;
    logic [3:0]          pk_mask;
    logic                word_closed;
    logic                wait_done;
    logic [4:0]          rd_off;

    assign pk_clear    = ((state_q == ST_IDLE) && wr_start) || (state_q == ST_WRITE);
    assign pk_accept   = (state_q == ST_FILL) && in_valid;
    assign word_closed = pk_accept && ((pk_lane == LAST_LANE) || in_last);
    assign wait_done   = (wait_q == WAIT_W'(RD_LAT - 1));
    assign rd_off      = lane_offset(rd_lane_q);

    ram32_byte_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .accept  (pk_accept),
        .byte_in (in_data),
        .lane    (pk_lane),
        .word    (pk_word),
        .mask    (pk_mask)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs; every output idles at zero outside the state that drives it.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'd0;
        ram_en    = 1'b0;
        ram_a     = '0;
        ram_we    = 4'd0;
        ram_di    = 32'd0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (wr_start) begin
                    state_d = ST_FILL;
                end else if (rd_start) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (word_closed) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_en  = 1'b1;
                ram_a   = addr_q;
                ram_di  = pk_word;
                ram_we  = pk_mask;
                state_d = last_q ? ST_IDLE : ST_FILL;
            end
            ST_RD_REQ: begin
                ram_en  = 1'b1;
                ram_a   = addr_q;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = shreg_q[rd_off +: 8];
                if (out_ready && (rd_lane_q == LAST_LANE)) begin
                    state_d = (remaining_q == LEN_W'(1)) ? ST_IDLE : ST_RD_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address, burst length, read latency counter and read shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            rd_lane_q   <= 2'd0;
            shreg_q     <= 32'd0;
            wait_q      <= '0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_start) begin
                        addr_q <= base_addr;
                        last_q <= 1'b0;
                    end else if (rd_start) begin
                        addr_q      <= base_addr;
                        remaining_q <= (rd_len == '0) ? LEN_W'(RAM_WORDS) : rd_len;
                    end
                end
                ST_FILL: begin
                    if (word_closed) begin
                        last_q <= in_last;
                    end
                end
                ST_WRITE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                ST_RD_REQ: begin
                    wait_q <= '0;
                end
                ST_RD_WAIT: begin
                    if (wait_done) begin
                        shreg_q   <= ram_do;
                        rd_lane_q <= 2'd0;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (rd_lane_q == LAST_LANE) begin
                            rd_lane_q   <= 2'd0;
                            remaining_q <= remaining_q - LEN_W'(1);
                            addr_q      <= addr_q + ADDR_W'(1);
                        end else begin
                            rd_lane_q <= rd_lane_q + 2'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
